// File: rtl/axi4_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi4_slave_pkg
// Shared definitions for the AXI4 slave write-path blocks.
//   - AXI B-channel response codes (OKAY / EXOKAY / SLVERR / DECERR)
//   - b_state_t : state of the B-channel presentation FSM
// No ports; imported with `import axi4_slave_pkg::*;`.
// ---------------------------------------------------------------------------
package axi4_slave_pkg;

    // AXI response codes carried on b_bresp / bresp
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // B-channel presentation state
    //   B_IDLE    : nothing queued, bvalid low
    //   B_PRESENT : head response driven, waiting for bready
    //   B_STALLED : head response driven, master has stalled past the timeout
    typedef enum logic [1:0] {
        B_IDLE    = 2'd0,
        B_PRESENT = 2'd1,
        B_STALLED = 2'd2
    } b_state_t;

endpackage

// File: rtl/axi4_resp_fifo.sv
// ---------------------------------------------------------------------------
// axi4_resp_fifo
// Generic synchronous FIFO holding queued B responses ({id, resp}).
// Read data is the entry at the read pointer (show-ahead), so the head is
// visible as soon as count_o is non-zero.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (pointers, count, storage -> 0)
//   push_i   in   write data_i at the tail this cycle
//   pop_i    in   drop the head entry this cycle
//   data_i   in   WIDTH  entry to write
//   data_o   out  WIDTH  head entry
//   count_o  out  entries held, 0..DEPTH
//   full_o   out  count_o == DEPTH
//   empty_o  out  count_o == 0
// ---------------------------------------------------------------------------
module axi4_resp_fifo
    import axi4_slave_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [WIDTH-1:0]               data_i,
    output logic [WIDTH-1:0]               data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pushEn;
    logic             popEn;

    // Guard against a pop on an empty queue or a push into a full queue
    // that is not being drained in the same cycle; callers normally gate
    // these already, so this only protects the pointers.
    assign popEn  = pop_i && (count_q != '0);
    assign pushEn = push_i && ((count_q != CNT_W'(DEPTH)) || popEn);

    // Pointer and occupancy next-state. DEPTH is a power of two, so the
    // pointers wrap from DEPTH-1 to 0 by plain overflow.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushEn && !popEn) begin
            count_d = count_q + CNT_W'(1);
        end else if (popEn && !pushEn) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage and pointer registers. Storage is cleared on reset so the
    // head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (pushEn) begin
                mem_q[wrPtr_q] <= data_i;
            end
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/axi4_slave_write_resp_channel.sv
// ---------------------------------------------------------------------------
// axi4_slave_write_resp_channel
// AXI4 slave B-channel stage. Queues responses produced by the write data
// channel (one-cycle b_transfer_done pulse) so that channel never waits on
// bready, and presents them in order with a full BVALID/BREADY handshake.
// Flags dropped pushes (queue overflow) and a master that holds bready low
// for TIMEOUT_CYCLES consecutive cycles while a response is pending.
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-high reset
//   b_transfer_done  in   push pulse, qualifies b_bid / b_bresp
//   b_bid            in   ID_WIDTH  ID of the completed burst
//   b_bresp          in   2         response of the completed burst
//   bready           in   master ready
//   bvalid           out  response valid (queue non-empty)
//   bid              out  ID_WIDTH  head response ID
//   bresp            out  2         head response code
//   resp_count       out  responses held, 0..RESP_DEPTH
//   resp_full        out  resp_count == RESP_DEPTH
//   resp_overflow    out  sticky, a push was dropped
//   b_timeout        out  sticky, bready stall reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module axi4_slave_write_resp_channel
    import axi4_slave_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int RESP_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                b_transfer_done,
    input  logic [ID_WIDTH-1:0]                 b_bid,
    input  logic [1:0]                          b_bresp,
    input  logic                                bready,
    output logic                                bvalid,
    output logic [ID_WIDTH-1:0]                 bid,
    output logic [1:0]                          bresp,
    output logic [$clog2(RESP_DEPTH+1)-1:0]     resp_count,
    output logic                                resp_full,
    output logic                                resp_overflow,
    output logic                                b_timeout
);

    localparam int CNT_W   = $clog2(RESP_DEPTH+1);
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES-1);
    localparam logic [STALL_W-1:0] STALL_MAX   = STALL_W'(TIMEOUT_CYCLES);

    b_state_t             state_q, state_d;
    logic [STALL_W-1:0]   stallCnt_q, stallCnt_d;
    logic                 overflow_q;
    logic                 timeout_q;

    logic [ID_WIDTH+1:0]  fifoRdata;
    logic [CNT_W-1:0]     fifoCount;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 pushEn;
    logic                 popEn;
    logic                 dropEn;
    logic                 leavesEmpty;
    logic                 timeoutHit;

    // bvalid comes straight from the registered occupancy, so it never
    // depends combinationally on bready or the push input.
    assign bvalid = !fifoEmpty;
    assign popEn  = bvalid && bready;
    // A full queue still accepts a push when the head leaves this cycle.
    assign pushEn = b_transfer_done && (!fifoFull || popEn);
    assign dropEn = b_transfer_done && fifoFull && !popEn;
    assign leavesEmpty = popEn && !pushEn && (fifoCount == CNT_W'(1));

    axi4_resp_fifo #(
        .WIDTH (ID_WIDTH + 2),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushEn),
        .pop_i   (popEn),
        .data_i  ({b_bid, b_bresp}),
        .data_o  (fifoRdata),
        .count_o (fifoCount),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Next state for the presentation FSM and the bready stall counter.
    // The stall counter restarts on every handshake and saturates so a
    // very long stall cannot wrap it back below the limit.
    always_comb begin
        state_d    = state_q;
        stallCnt_d = stallCnt_q;
        timeoutHit = 1'b0;

        if (!bvalid || popEn) begin
            stallCnt_d = '0;
        end else if (stallCnt_q != STALL_MAX) begin
            stallCnt_d = stallCnt_q + STALL_W'(1);
        end

        case (state_q)
            B_IDLE: begin
                if (pushEn) begin
                    state_d = B_PRESENT;
                end
            end
            B_PRESENT: begin
                if (popEn) begin
                    if (leavesEmpty) begin
                        state_d = B_IDLE;
                    end
                end else if (stallCnt_q == STALL_LIMIT) begin
                    state_d    = B_STALLED;
                    timeoutHit = 1'b1;
                end
            end
            B_STALLED: begin
                // The timeout only reports; the entry stays until taken.
                if (popEn) begin
                    state_d = leavesEmpty ? B_IDLE : B_PRESENT;
                end
            end
            default: begin
                state_d = B_IDLE;
            end
        endcase
    end

    // State, stall counter and the two sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= B_IDLE;
            stallCnt_q <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stallCnt_q <= stallCnt_d;
            overflow_q <= overflow_q | dropEn;
            timeout_q  <= timeout_q | timeoutHit;
        end
    end

    assign bid           = fifoRdata[ID_WIDTH+1:2];
    assign bresp         = fifoRdata[1:0];
    assign resp_count    = fifoCount;
    assign resp_full     = fifoFull;
    assign resp_overflow = overflow_q;
    assign b_timeout     = timeout_q;

endmodule

// File: tb/tb_axi4_slave_write_resp_channel.sv
// ---------------------------------------------------------------------------
// tb_axi4_slave_write_resp_channel
// Self-checking bench. A queue-based reference model tracks the responses
// that should be held, the length of the current bready stall and the two
// sticky flags; every cycle the DUT outputs are compared against it.
// Inputs change on the falling edge, outputs are compared on the next
// falling edge after the rising edge that consumed them.
// ---------------------------------------------------------------------------
module tb_axi4_slave_write_resp_channel;
    import axi4_slave_pkg::*;

    localparam int ID_W    = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              b_transfer_done;
    logic [ID_W-1:0]   b_bid;
    logic [1:0]        b_bresp;
    logic              bready;
    logic              bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [CNT_W-1:0]  resp_count;
    logic              resp_full;
    logic              resp_overflow;
    logic              b_timeout;

    always #5 clk = ~clk;

    axi4_slave_write_resp_channel #(
        .ID_WIDTH       (ID_W),
        .RESP_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .b_transfer_done (b_transfer_done),
        .b_bid           (b_bid),
        .b_bresp         (b_bresp),
        .bready          (bready),
        .bvalid          (bvalid),
        .bid             (bid),
        .bresp           (bresp),
        .resp_count      (resp_count),
        .resp_full       (resp_full),
        .resp_overflow   (resp_overflow),
        .b_timeout       (b_timeout)
    );

    // Reference model state
    logic [ID_W+1:0] modelQ [$];
    bit              modelOverflow;
    bit              modelTimeout;
    bit              modelClear;
    int              stallRun;

    int checkCount = 0;
    int passCount  = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model across the rising
    // edge, then compares every output on the following falling edge.
    task automatic applyStimulus(input logic rstV, input logic doneV,
                                 input logic [ID_W-1:0] idV,
                                 input logic [1:0] respV, input logic readyV);
        bit hadPop;
        bit wasFull;
        rst             = rstV;
        b_transfer_done = doneV;
        b_bid           = idV;
        b_bresp         = respV;
        bready          = readyV;
        @(posedge clk);
        if (rstV) begin
            modelQ.delete();
            modelOverflow = 1'b0;
            modelTimeout  = 1'b0;
            modelClear    = 1'b1;
            stallRun      = 0;
        end else begin
            hadPop  = (modelQ.size() != 0) && readyV;
            wasFull = (modelQ.size() == DEPTH);
            if (hadPop) begin
                void'(modelQ.pop_front());
                stallRun = 0;
            end else if (modelQ.size() != 0) begin
                stallRun++;
                if (stallRun >= TIMEOUT) modelTimeout = 1'b1;
            end
            if (doneV) begin
                if (!wasFull || hadPop) begin
                    modelQ.push_back({idV, respV});
                    modelClear = 1'b0;
                end else begin
                    modelOverflow = 1'b1;
                end
            end
        end
        @(negedge clk);
        checkOutput("bvalid", 32'(bvalid), 32'(modelQ.size() != 0));
        checkOutput("resp_count", 32'(resp_count), 32'(modelQ.size()));
        checkOutput("resp_full", 32'(resp_full), 32'(modelQ.size() == DEPTH));
        checkOutput("resp_overflow", 32'(resp_overflow), 32'(modelOverflow));
        checkOutput("b_timeout", 32'(b_timeout), 32'(modelTimeout));
        if (modelQ.size() != 0) begin
            checkOutput("bid", 32'(bid), 32'(modelQ[0][ID_W+1:2]));
            checkOutput("bresp", 32'(bresp), 32'(modelQ[0][1:0]));
        end else if (modelClear) begin
            checkOutput("bid_reset", 32'(bid), 32'(0));
            checkOutput("bresp_reset", 32'(bresp), 32'(0));
        end
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, '0, OKAY, 1'b0);
    endtask

    task automatic idle(input logic readyV, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, OKAY, readyV);
    endtask

    initial begin
        int readyPct;
        rst             = 1'b1;
        b_transfer_done = 1'b0;
        b_bid           = '0;
        b_bresp         = OKAY;
        bready          = 1'b0;
        modelClear      = 1'b1;
        @(negedge clk);

        $display("[TB] reset state");
        resetDut();
        resetDut();

        $display("[TB] single response");
        applyStimulus(1'b0, 1'b1, 4'h3, OKAY, 1'b1);
        idle(1'b1, 2);

        $display("[TB] back-pressure");
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, ID_W'(i), SLVERR, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 5);

        $display("[TB] overflow");
        resetDut();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, ID_W'(i), OKAY, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h5, DECERR, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h6, EXOKAY, 1'b1);
        idle(1'b1, 5);

        $display("[TB] simultaneous push/pop with pointer wrap");
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'h8, OKAY, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, ID_W'(9 + i), 2'(i), 1'b1);
        idle(1'b1, 2);

        $display("[TB] bready stall timeout");
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'hA, SLVERR, 1'b0);
        idle(1'b0, TIMEOUT + 2);
        idle(1'b1, 2);

        $display("[TB] reset mid-operation");
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, ID_W'(i + 11), OKAY, 1'b0);
        resetDut();
        applyStimulus(1'b0, 1'b1, 4'h7, EXOKAY, 1'b0);
        idle(1'b1, 2);

        $display("[TB] randomized traffic");
        resetDut();
        for (int blk = 0; blk < 12; blk++) begin
            readyPct = int'($urandom_range(0, 100));
            for (int i = 0; i < 40; i++) begin
                applyStimulus(($urandom_range(0, 149) == 0),
                              1'($urandom_range(0, 1)),
                              ID_W'($urandom),
                              2'($urandom),
                              (int'($urandom_range(0, 99)) < readyPct));
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
